// File: rtl/disp_sched.sv
// disp_sched: shares the display's numeric field between two sources and converts the value to BCD digit words
module disp_sched #(
    parameter int HOLD_CYCLES = 100000000,
    parameter int CNT_W = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  prog,
    input  logic [1:0]  modulo,
    input  logic [15:0] data_a,
    input  logic [15:0] data_b,
    input  logic [1:0]  sel_mode,
    output logic [5:0]  d1,
    output logic [5:0]  d2,
    output logic [5:0]  d3,
    output logic [5:0]  d4,
    output logic [5:0]  d5,
    output logic [5:0]  d6,
    output logic [5:0]  d7,
    output logic [5:0]  d8,
    output logic        src,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;
    state_t state;
    logic [CNT_W-1:0] timer;
    logic pend;
    logic conv_src;
    logic [15:0] bin;
    logic [19:0] bcd;
    logic [3:0] cnt;
    logic [19:0] adj;
    logic [19:0] nb;
    // double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit
    always_comb begin
        adj = bcd;
        for (int i = 0; i < 5; i++)
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        nb = {adj[18:0], bin[15]};
    end
    // pending source: fixed by sel_mode, or toggled at each wrap of the rotation timer
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
            pend <= 1'b0;
        end else if (sel_mode == 2'b10) begin
            timer <= (timer == CNT_W'(HOLD_CYCLES - 1)) ? '0 : timer + 1'b1;
            pend <= (timer == CNT_W'(HOLD_CYCLES - 1)) ? ~pend : pend;
        end else begin
            timer <= '0;
            pend <= (sel_mode == 2'b01);
        end
    end
    // program and mode digits follow their inputs with one cycle of latency
    always_ff @(posedge clk) begin
        if (rst) begin
            d6 <= '0;
            d8 <= '0;
        end else begin
            d6 <= {1'b1, 2'b00, modulo, 1'b0};
            d8 <= {1'b1, 1'b0, prog, 1'b0};
        end
    end
    // conversion sequencer; the digit field is written only on entry to COMMIT from the final shift
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            bin <= '0;
            bcd <= '0;
            cnt <= '0;
            conv_src <= 1'b0;
            src <= 1'b0;
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
            d4 <= '0;
            d5 <= '0;
            d7 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= LOAD;
                    busy <= 1'b1;
                end
                LOAD: begin
                    bin <= pend ? data_b : data_a;
                    conv_src <= pend;
                    bcd <= '0;
                    cnt <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    bcd <= nb;
                    bin <= {bin[14:0], 1'b0};
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state <= COMMIT;
                        busy <= 1'b0;
                        src <= conv_src;
                        d1 <= {1'b1, nb[3:0], 1'b0};
                        d2 <= (|nb[19:4]) ? {1'b1, nb[7:4], 1'b0} : 6'd0;
                        d3 <= (|nb[19:8]) ? {1'b1, nb[11:8], 1'b0} : 6'd0;
                        d4 <= (|nb[19:12]) ? {1'b1, nb[15:12], 1'b0} : 6'd0;
                        d5 <= (|nb[19:16]) ? {1'b1, nb[19:16], 1'b0} : 6'd0;
                        d7 <= {1'b1, conv_src ? 4'hB : 4'hA, 1'b0};
                    end
                end
                COMMIT: begin
                    state <= LOAD;
                    busy <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_disp_sched.sv
// tb_disp_sched: directed vectors and corner-case sequences for disp_sched
module tb_disp_sched;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] prog;
    logic [1:0] modulo, sel_mode;
    logic [15:0] data_a, data_b;
    logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
    logic src, busy;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    disp_sched #(.HOLD_CYCLES(40), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .prog(prog), .modulo(modulo),
        .data_a(data_a), .data_b(data_b), .sel_mode(sel_mode),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8),
        .src(src), .busy(busy)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  pg;
        logic [1:0]  md;
        logic [5:0]  e1, e2, e3, e4, e5;
        logic        s;
    } vec_t;
    vec_t v[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] w(input logic [3:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_d1"}, 16'(d1), 16'd0);
        chk({tag, "_d2"}, 16'(d2), 16'd0);
        chk({tag, "_d3"}, 16'(d3), 16'd0);
        chk({tag, "_d4"}, 16'(d4), 16'd0);
        chk({tag, "_d5"}, 16'(d5), 16'd0);
        chk({tag, "_d6"}, 16'(d6), 16'd0);
        chk({tag, "_d7"}, 16'(d7), 16'd0);
        chk({tag, "_d8"}, 16'(d8), 16'd0);
        chk({tag, "_src"}, 16'(src), 16'd0);
        chk({tag, "_busy"}, 16'(busy), 16'd0);
    endtask

    initial begin
        logic [5:0] prev1, last3, last7, exp3, exp7;
        logic mp, cap;
        int mt;
        v[0] = '{2'b00, 16'd1234,  16'd0,   3'd1, 2'd0, w(4), w(3), w(2), w(1), 6'd0, 1'b0};
        v[1] = '{2'b01, 16'd1234,  16'd7,   3'd2, 2'd1, w(7), 6'd0, 6'd0, 6'd0, 6'd0, 1'b1};
        v[2] = '{2'b00, 16'd65535, 16'd7,   3'd7, 2'd3, w(5), w(3), w(5), w(5), w(6), 1'b0};
        v[3] = '{2'b00, 16'd0,     16'd7,   3'd0, 2'd2, w(0), 6'd0, 6'd0, 6'd0, 6'd0, 1'b0};
        v[4] = '{2'b11, 16'd10000, 16'd7,   3'd4, 2'd1, w(0), w(0), w(0), w(0), w(1), 1'b0};
        v[5] = '{2'b01, 16'd0,     16'd305, 3'd6, 2'd0, w(5), w(0), w(3), 6'd0, 6'd0, 1'b1};
        v[6] = '{2'b00, 16'd99,    16'd305, 3'd3, 2'd3, w(9), w(9), 6'd0, 6'd0, 6'd0, 1'b0};

        rst = 1'b1;
        prog = 3'd3;
        modulo = 2'd1;
        sel_mode = 2'b00;
        data_a = 16'd0;
        data_b = 16'd0;
        repeat (3) tick();
        chk_all_zero("reset");

        prev1 = 6'd0;
        for (int i = 0; i < 7; i++) begin
            sel_mode = v[i].sel;
            data_a = v[i].a;
            data_b = v[i].b;
            prog = v[i].pg;
            modulo = v[i].md;
            rst = 1'b0;
            repeat (17) tick();
            chk("hold_d1", 16'(d1), 16'(prev1));
            chk("busy_mid", 16'(busy), 16'd1);
            tick();
            chk("vec_d1", 16'(d1), 16'(v[i].e1));
            chk("vec_d2", 16'(d2), 16'(v[i].e2));
            chk("vec_d3", 16'(d3), 16'(v[i].e3));
            chk("vec_d4", 16'(d4), 16'(v[i].e4));
            chk("vec_d5", 16'(d5), 16'(v[i].e5));
            chk("vec_d6", 16'(d6), 16'({1'b1, 2'b00, v[i].md, 1'b0}));
            chk("vec_d7", 16'(d7), 16'(v[i].s ? w(4'hB) : w(4'hA)));
            chk("vec_d8", 16'(d8), 16'({1'b1, 1'b0, v[i].pg, 1'b0}));
            chk("vec_src", 16'(src), 16'(v[i].s));
            chk("vec_busy", 16'(busy), 16'd0);
            prev1 = v[i].e1;
        end

        sel_mode = 2'b00;
        data_a = 16'd111;
        repeat (6) tick();
        data_a = 16'd999;
        repeat (12) tick();
        chk("midchg_d1", 16'(d1), 16'(w(1)));
        chk("midchg_d2", 16'(d2), 16'(w(1)));
        chk("midchg_d3", 16'(d3), 16'(w(1)));
        chk("midchg_d4", 16'(d4), 16'd0);
        repeat (18) tick();
        chk("next_d1", 16'(d1), 16'(w(9)));
        chk("next_d2", 16'(d2), 16'(w(9)));
        chk("next_d3", 16'(d3), 16'(w(9)));

        data_a = 16'd100;
        data_b = 16'd200;
        mp = 1'b0;
        mt = 0;
        cap = 1'b0;
        last3 = w(9);
        last7 = w(4'hA);
        for (int k = 1; k <= 198; k++) begin
            sel_mode = (k <= 108) ? 2'b10 : (k <= 126) ? 2'b01 : 2'b10;
            if (k % 18 == 2) cap = mp;
            if (sel_mode == 2'b10) begin
                if (mt == 39) begin
                    mt = 0;
                    mp = ~mp;
                end else mt++;
            end else begin
                mt = 0;
                mp = (sel_mode == 2'b01);
            end
            tick();
            if (k % 18 == 0) begin
                exp3 = cap ? w(2) : w(1);
                exp7 = cap ? w(4'hB) : w(4'hA);
                chk("auto_src", 16'(src), 16'(cap));
                chk("auto_d3", 16'(d3), 16'(exp3));
                chk("auto_d7", 16'(d7), 16'(exp7));
                chk("auto_busy", 16'(busy), 16'd0);
                last3 = exp3;
                last7 = exp7;
            end else begin
                chk("glitch_d3", 16'(d3), 16'(last3));
                chk("glitch_d7", 16'(d7), 16'(last7));
            end
        end

        sel_mode = 2'b00;
        data_a = 16'd999;
        repeat (6) tick();
        rst = 1'b1;
        prog = 3'd5;
        modulo = 2'd2;
        tick();
        rst = 1'b0;
        chk_all_zero("midrst");
        tick();
        chk("rel_d8", 16'(d8), 16'(6'h2A));
        chk("rel_d6", 16'(d6), 16'(6'h24));
        chk("rel_d1", 16'(d1), 16'd0);
        repeat (16) tick();
        chk("refill_pre_d1", 16'(d1), 16'd0);
        chk("refill_pre_busy", 16'(busy), 16'd1);
        tick();
        chk("refill_d1", 16'(d1), 16'(w(9)));
        chk("refill_d3", 16'(d3), 16'(w(9)));
        chk("refill_d4", 16'(d4), 16'd0);
        chk("refill_d7", 16'(d7), 16'(w(4'hA)));
        chk("refill_src", 16'(src), 16'd0);
        chk("refill_busy", 16'(busy), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
